// File: rtl/alu_sequencer_if.sv
// Command / ALU / response bundle for alu_sequencer.
// Ports: in_* command handshake, alu_* ALU drive/return, out_* response handshake.
interface alu_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [10:0]      in_opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_err;

    modport master (
        output in_valid, in_opcode, in_a, in_b,
        output alu_result, alu_carry, out_ready,
        input  in_ready, alu_a, alu_b, alu_op,
        input  out_valid, out_result, out_carry, out_err
    );

    modport slave (
        input  in_valid, in_opcode, in_a, in_b,
        input  alu_result, alu_carry, out_ready,
        output in_ready, alu_a, alu_b, alu_op,
        output out_valid, out_result, out_carry, out_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// LEGv8 R-type command sequencer driving an external ALU (IDLE/EXEC/DONE).
// Ports: clk, rst (sync, active-high), bus (alu_sequencer_if.slave).
// Optional: define ALU_SEQ_DIVZERO_CHK_EN to reject UDIV by zero.
module alu_sequencer #(
    parameter int WIDTH    = 64,
    parameter int MUL_WAIT = 2,
    parameter int DIV_WAIT = 4
) (
    input logic            clk,
    input logic            rst,
    alu_sequencer_if.slave bus
);
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_MUL  = 11'b10011011000;
    localparam logic [10:0] OPC_UDIV = 11'b10011010110;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_UDIV = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_ORR  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_op;
    logic [WIDTH-1:0] r_out_result;
    logic             r_out_carry;
    logic             r_out_err;

    logic             w_legal;
    logic [3:0]       w_op;
    logic [3:0]       w_n;
    logic             w_divz;

    always_comb begin
        w_legal = 1'b1;
        w_op    = OP_ADD;
        w_n     = 4'd1;
        unique case (bus.in_opcode)
            OPC_ADD:  w_op = OP_ADD;
            OPC_SUB:  w_op = OP_SUB;
            OPC_AND:  w_op = OP_AND;
            OPC_ORR:  w_op = OP_ORR;
            OPC_MUL: begin
                w_op = OP_MUL;
                w_n  = 4'(MUL_WAIT);
            end
            OPC_UDIV: begin
                w_op = OP_UDIV;
                w_n  = 4'(DIV_WAIT);
            end
            default:  w_legal = 1'b0;
        endcase
    end

`ifdef ALU_SEQ_DIVZERO_CHK_EN
    assign w_divz = (bus.in_opcode == OPC_UDIV) && (bus.in_b == '0);
`else
    assign w_divz = 1'b0;
`endif

    // Handshake flags are pure state decodes, so they can never overlap.
    assign bus.in_ready   = (r_state == IDLE);
    assign bus.out_valid  = (r_state == DONE);
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_op     = r_alu_op;
    assign bus.out_result = r_out_result;
    assign bus.out_carry  = r_out_carry;
    assign bus.out_err    = r_out_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= 4'd0;
            r_out_result <= '0;
            r_out_carry  <= 1'b0;
            r_out_err    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (!w_legal || w_divz) begin
                            // Rejected commands bypass the ALU entirely.
                            r_state      <= DONE;
                            r_out_result <= w_divz ? '1 : '0;
                            r_out_carry  <= 1'b0;
                            r_out_err    <= 1'b1;
                        end else begin
                            r_state  <= EXEC;
                            r_alu_a  <= bus.in_a;
                            r_alu_b  <= bus.in_b;
                            r_alu_op <= w_op;
                            r_cnt    <= w_n - 4'd1;
                        end
                    end
                end
                EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= DONE;
                        r_out_result <= bus.alu_result;
                        r_out_carry  <= (r_alu_op == OP_ADD) && bus.alu_carry;
                        r_out_err    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model.
// Ports: none (drives the DUT through an alu_sequencer_if instance).
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_sequencer_if #(.WIDTH(64)) bus ();

    alu_sequencer #(
        .WIDTH(64),
        .MUL_WAIT(2),
        .DIV_WAIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    localparam logic [63:0] DIVZ_VAL = 64'h5A5A_5A5A_5A5A_5A5A;

    // External ALU model; SUB raises carry on no-borrow so a leak shows up.
    always_comb begin
        bus.alu_result = 64'd0;
        bus.alu_carry  = 1'b0;
        case (bus.alu_op)
            4'b0000: {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            4'b0001: begin
                bus.alu_result = bus.alu_a - bus.alu_b;
                bus.alu_carry  = (bus.alu_a >= bus.alu_b);
            end
            4'b0010: bus.alu_result = bus.alu_a * bus.alu_b;
            4'b0011: bus.alu_result = (bus.alu_b == 64'd0) ? DIVZ_VAL : bus.alu_a / bus.alu_b;
            4'b1000: bus.alu_result = bus.alu_a & bus.alu_b;
            4'b1001: bus.alu_result = bus.alu_a | bus.alu_b;
            default: bus.alu_result = 64'd0;
        endcase
    end

    typedef struct {
        string       name;
        logic [10:0] opc;
        logic [63:0] a;
        logic [63:0] b;
        int          lat;
        logic [63:0] res;
        logic        carry;
        logic        err;
        logic [3:0]  op;
    } vec_t;

    vec_t vecs[10];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [10:0] opc, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_opcode = opc;
        bus.in_a      = a;
        bus.in_b      = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Edges counted from the accept edge until out_valid is seen.
    task automatic wait_valid(output int k);
        k = 0;
        while (!bus.out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic release_resp(input string name);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({name, ".in_ready_after"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int          k;
        logic [63:0] s_res;
        logic        s_err;
        logic        seen;

        bus.in_valid  = 1'b0;
        bus.in_opcode = 11'd0;
        bus.in_a      = 64'd0;
        bus.in_b      = 64'd0;
        bus.out_ready = 1'b0;

        vecs[0] = '{"add_ovf", 11'b10001011000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 64'd0, 1'b1, 1'b0, 4'b0000};
        vecs[1] = '{"add",     11'b10001011000, 64'd2, 64'd3, 1, 64'd5, 1'b0, 1'b0, 4'b0000};
        vecs[2] = '{"sub",     11'b11001011000, 64'd5, 64'd3, 1, 64'd2, 1'b0, 1'b0, 4'b0001};
        vecs[3] = '{"mul",     11'b10011011000, 64'd3, 64'd5, 2, 64'd15, 1'b0, 1'b0, 4'b0010};
        vecs[4] = '{"udiv",    11'b10011010110, 64'd100, 64'd7, 4, 64'd14, 1'b0, 1'b0, 4'b0011};
        vecs[5] = '{"and",     11'b10001010000, 64'hF0F0, 64'hFF00, 1, 64'hF000, 1'b0, 1'b0, 4'b1000};
        vecs[6] = '{"orr",     11'b10101010000, 64'hF0F0, 64'h0F0F, 1, 64'hFFFF, 1'b0, 1'b0, 4'b1001};
        vecs[7] = '{"ill_ones", 11'b11111111111, 64'd9, 64'd9, 0, 64'd0, 1'b0, 1'b1, 4'b1001};
`ifdef ALU_SEQ_DIVZERO_CHK_EN
        vecs[8] = '{"udiv_z",  11'b10011010110, 64'd9, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 4'b1001};
        vecs[9] = '{"ill_near", 11'b10001011001, 64'd1, 64'd1, 0, 64'd0, 1'b0, 1'b1, 4'b1001};
`else
        vecs[8] = '{"udiv_z",  11'b10011010110, 64'd9, 64'd0, 4, DIVZ_VAL, 1'b0, 1'b0, 4'b0011};
        vecs[9] = '{"ill_near", 11'b10001011001, 64'd1, 64'd1, 0, 64'd0, 1'b0, 1'b1, 4'b0011};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.out_result", bus.out_result, 64'd0);
        chk("rst.alu_op", 64'(bus.alu_op), 64'd0);

        foreach (vecs[i]) begin
            issue(vecs[i].opc, vecs[i].a, vecs[i].b);
            if (vecs[i].lat > 0) begin
                chk({vecs[i].name, ".alu_op_exec"}, 64'(bus.alu_op), 64'(vecs[i].op));
                chk({vecs[i].name, ".in_ready_busy"}, 64'(bus.in_ready), 64'd0);
            end
            wait_valid(k);
            chk({vecs[i].name, ".latency"}, 64'(k), 64'(vecs[i].lat));
            chk({vecs[i].name, ".result"}, bus.out_result, vecs[i].res);
            chk({vecs[i].name, ".carry"}, 64'(bus.out_carry), 64'(vecs[i].carry));
            chk({vecs[i].name, ".err"}, 64'(bus.out_err), 64'(vecs[i].err));
            chk({vecs[i].name, ".alu_op_held"}, 64'(bus.alu_op), 64'(vecs[i].op));
            chk({vecs[i].name, ".no_overlap"}, 64'(bus.in_ready), 64'd0);
            release_resp(vecs[i].name);
        end

        // Illegal command held in DONE for three cycles with out_ready low
        issue(11'b11111111111, 64'd1, 64'd2);
        wait_valid(k);
        chk("hold.latency", 64'(k), 64'd0);
        s_res = bus.out_result;
        s_err = bus.out_err;
        chk("hold.err", 64'(s_err), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("hold.valid", 64'(bus.out_valid), 64'd1);
            chk("hold.result", bus.out_result, 64'd0);
            chk("hold.err_stable", 64'(bus.out_err), 64'(s_err));
        end
        release_resp("hold");

        // Reset during second EXEC cycle of UDIV
        issue(11'b10011010110, 64'd100, 64'd7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstx.in_ready", 64'(bus.in_ready), 64'd1);
        chk("rstx.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rstx.out_result", bus.out_result, 64'd0);
        chk("rstx.out_err", 64'(bus.out_err), 64'd0);
        chk("rstx.out_carry", 64'(bus.out_carry), 64'd0);
        chk("rstx.alu_a", bus.alu_a, 64'd0);
        chk("rstx.alu_b", bus.alu_b, 64'd0);
        chk("rstx.alu_op", 64'(bus.alu_op), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("rstx.no_response", 64'(seen), 64'd0);

        // Sequencer still usable after the abandoned command
        issue(11'b10001011000, 64'd40, 64'd2);
        wait_valid(k);
        chk("post.latency", 64'(k), 64'd1);
        chk("post.result", bus.out_result, 64'd42);
        release_resp("post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, 64, operand/result width.
REQ-002 Parameter: MUL_WAIT, 2, EXEC cycles for MUL (legal range 1-15).
REQ-003 Parameter: DIV_WAIT, 4, EXEC cycles for UDIV (legal range 1-15).
REQ-004 Clocking SHALL be one clock `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  command offered.
REQ-008 in_ready  output  1  sequencer can accept a command.
REQ-009 in_opcode  input  11  LEGv8 R-type opcode.
REQ-010 in_a, in_b  input  WIDTH  operands (Rn, Rm).
REQ-011 alu_a, alu_b  output  WIDTH  operands driven to the ALU.
REQ-012 alu_op  output  4  ALU operation code.
REQ-013 alu_result  input  WIDTH  ALU result.
REQ-014 alu_carry  input  1  ALU carry out of the add path.
REQ-015 out_valid  output  1  response available.
REQ-016 out_ready  input  1  consumer accepts response.
REQ-017 out_result  output  WIDTH  captured result.
REQ-018 out_carry, out_err  output  1 each  carry flag; illegal-command flag.

Function
REQ-019 Decode SHALL map ADD 10001011000->0000, SUB 11001011000->0001, MUL 10011011000->0010, UDIV 10011010110->0011, AND 10001010000->1000, ORR 10101010000->1001; any other opcode is illegal.
REQ-020 FSM SHALL have exactly the states IDLE, EXEC and DONE.
REQ-021 in_ready SHALL be 1 only in IDLE; there is no command overlap.
REQ-022 Accept SHALL occur when in_valid && in_ready at edge T: operands and code are registered and the FSM enters EXEC, with alu_a, alu_b and alu_op valid from T+1.
REQ-023 EXEC length N SHALL be 1 cycle for ADD/SUB/AND/ORR, MUL_WAIT for MUL and DIV_WAIT for UDIV, counted by a 4-bit down-counter.
REQ-024 On the last EXEC cycle, alu_result SHALL be captured into out_result; out_carry SHALL take alu_carry for ADD and 0 otherwise. The FSM then enters DONE, so out_valid rises N+1 cycles after accept.
REQ-025 An illegal opcode SHALL skip EXEC: IDLE->DONE at T+1 with out_err=1, out_result=0, out_carry=0, and alu_* unchanged.
REQ-026 In DONE, out_valid=1 and all out_* SHALL stay stable until out_ready=1; that transfer returns the FSM to IDLE at the next edge.
REQ-027 out_valid and in_ready SHALL never both be 1, so no same-cycle accept-after-response occurs.
REQ-028 alu_a, alu_b and alu_op SHALL hold their last issued values outside EXEC.
REQ-029 out_err SHALL be 0 for every legal command, except as stated in REQ-034.

Reset
REQ-030 While rst=1 at an edge, the FSM SHALL go to IDLE and the counter to 0, with in_ready=1 after the edge.
REQ-031 While rst=1 at an edge, out_valid, out_result, out_carry, out_err, alu_a, alu_b and alu_op SHALL all be 0.
REQ-032 Reset during EXEC or DONE SHALL abandon the command; no response is produced for it.

Configuration
REQ-033 The macro ALU_SEQ_DIVZERO_CHK_EN SHALL control divide-by-zero checking.
REQ-034 With ALU_SEQ_DIVZERO_CHK_EN defined, UDIV with in_b==0 SHALL be treated like an illegal opcode (no EXEC, DONE at T+1) but with out_result set to all ones and out_err=1.
REQ-035 Without ALU_SEQ_DIVZERO_CHK_EN, UDIV by zero SHALL execute normally for DIV_WAIT cycles, capture whatever alu_result holds, and set out_err=0.

Verification
REQ-036 ADD, a=FFFF_FFFF_FFFF_FFFF, b=1, accept at T -> out_valid at T+2, result 0, carry 1, err 0.
REQ-037 MUL, a=3, b=5, MUL_WAIT=2 -> alu_op=0010 for T+1..T+2; out_valid at T+3, result 15, carry 0.
REQ-038 UDIV, a=100, b=7, DIV_WAIT=4 -> out_valid at T+5, result 14; in_ready=0 from T+1 until the response transfers.
REQ-039 Opcode 11111111111 -> out_valid at T+1, err 1, result 0; hold out_ready=0 for 3 cycles -> all outputs stable; release -> in_ready=1 on the next cycle.
REQ-040 UDIV b=0 -> macro on: T+1, result all ones, err 1; macro off: T+5, err 0.
REQ-041 rst=1 during the 2nd EXEC cycle of UDIV -> IDLE, all outputs 0, and no out_valid for that command.
